uart_frame_ctrl: RTL and testbench

- Sequences the byte stream from the UART receiver (8-N-1, one-cycle data-valid pulse per byte) into framed host commands for the order engine.
- Hunts for a sync byte, then collects opcode, length, payload and XOR checksum.
- Buffers the payload and holds a validated frame until the consumer acknowledges it.
- Reports framing errors as coded one-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_frame_ctrl_if.sv | 25 ++
 rtl/uart_frame_buf.sv | 33 +++
 rtl/uart_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART command framer
package uart_pkg;

    localparam int CLKS_PER_BIT = 1736;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_OPCODE  = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_OVERRUN = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CKS     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// rtl/uart_frame_ctrl_if.sv - receiver byte stream, frame handoff and error lines of the framer
interface uart_frame_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              o_Frame_Valid;
    logic [7:0]        o_Opcode;
    logic [7:0]        o_Length;
    logic              i_Frame_Ack;
    logic [ADDR_W-1:0] i_Rd_Addr;
    logic [7:0]        o_Rd_Data;
    logic              o_Err;
    logic [1:0]        o_Err_Code;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Frame_Ack, i_Rd_Addr,
        input  o_Frame_Valid, o_Opcode, o_Length, o_Rd_Data, o_Err, o_Err_Code
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Frame_Ack, i_Rd_Addr,
        output o_Frame_Valid, o_Opcode, o_Length, o_Rd_Data, o_Err, o_Err_Code
    );
endinterface

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload store, one write port and a registered read port
module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_We,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [7:0]        i_Wr_Data,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    // Storage carries no reset so it maps onto distributed RAM.
    always_ff @(posedge i_Clock) begin
        if (i_We) begin
            mem_q[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[i_Rd_Addr];
        end
    end

    assign o_Rd_Data = rd_q;
endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - sync hunt, header/payload/checksum parse and frame hold for host commands
// Inter-byte timeout exists only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_PAYLOAD  = 16,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 10 * CLKS_PER_BIT
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    uart_frame_ctrl_if.slave  bus
);
    if ((2 ** ADDR_W) < MAX_PAYLOAD || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 256 || TIMEOUT_CLKS < 2) begin : g_param_chk
        $error("uart_frame_ctrl: inconsistent parameters");
    end

    state_t            state_q, state_d;
    logic [7:0]        opc_q, opc_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    err_code_t         code_q, code_d;
    logic              buf_we;
    logic              timeout_w;

    logic       dv;
    logic [7:0] rx;
    logic       len_bad;
    logic       last_byte;

    assign dv        = bus.i_Rx_DV;
    assign rx        = bus.i_Rx_Byte;
    assign len_bad   = {1'b0, rx} > 9'(MAX_PAYLOAD);
    assign last_byte = (9'(cnt_q) + 9'd1) == {1'b0, len_q};

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CLKS);
    logic [GAP_W-1:0] gap_q;
    logic             active_w;

    assign active_w  = (state_q == S_OPCODE) || (state_q == S_LEN) ||
                       (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // A byte landing on the expiry cycle is processed instead of timing out.
    assign timeout_w = active_w && !dv && (gap_q == GAP_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            gap_q <= '0;
        end else if (dv || !active_w || timeout_w) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + 1'b1;
        end
    end
`else
    assign timeout_w = 1'b0;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_SYNC;
            opc_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_OVERRUN;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC:    if (dv && rx == SYNC_BYTE) state_d = S_OPCODE;
            S_OPCODE:  if (dv) state_d = S_LEN;
            S_LEN: begin
                if (dv) begin
                    if (len_bad)        state_d = S_SYNC;
                    else if (rx == '0)  state_d = S_CHECK;
                    else                state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: if (dv && last_byte) state_d = S_CHECK;
            S_CHECK:   if (dv) state_d = (rx == acc_q) ? S_HOLD : S_SYNC;
            S_HOLD:    if (bus.i_Frame_Ack) state_d = S_SYNC;
            default:   state_d = S_SYNC;
        endcase
        if (timeout_w) state_d = S_SYNC;
    end

    always_comb begin
        opc_d  = opc_q;
        len_d  = len_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        code_d = ERR_OVERRUN;
        buf_we = 1'b0;
        case (state_q)
            S_SYNC: if (dv && rx == SYNC_BYTE) acc_d = '0;
            S_OPCODE: begin
                if (dv) begin
                    opc_d = rx;
                    acc_d = acc_q ^ rx;
                end
            end
            S_LEN: begin
                if (dv && len_bad) begin
                    err_d  = 1'b1;
                    code_d = ERR_LEN;
                end else if (dv) begin
                    len_d = rx;
                    acc_d = acc_q ^ rx;
                    cnt_d = '0;
                end
            end
            S_PAYLOAD: begin
                if (dv) begin
                    buf_we = 1'b1;
                    acc_d  = acc_q ^ rx;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (dv && rx != acc_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_CKS;
                end
            end
            S_HOLD: begin
                if (dv) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: ;
        endcase
        if (timeout_w) begin
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
        end
    end

    assign bus.o_Frame_Valid = (state_q == S_HOLD);
    assign bus.o_Opcode      = opc_q;
    assign bus.o_Length      = len_q;
    assign bus.o_Err         = err_q;
    assign bus.o_Err_Code    = code_q;

    uart_frame_buf #(
        .DEPTH  (MAX_PAYLOAD),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_We      (buf_we),
        .i_Wr_Addr (cnt_q),
        .i_Wr_Data (rx),
        .i_Rd_Addr (bus.i_Rd_Addr),
        .o_Rd_Data (bus.o_Rd_Data)
    );
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - randomized bench for uart_frame_ctrl against a byte-queue frame model
module tb_uart_frame_ctrl;
    localparam int MAXP = 16;
    localparam int TO   = 17360;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_ctrl_if #(.ADDR_W(4)) bus();

    uart_frame_ctrl #(
        .MAX_PAYLOAD  (MAXP),
        .ADDR_W       (4),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    logic [7:0] m_pay[$];
    bit         m_hold = 1'b0;
    logic [7:0] m_opc = 8'h00;
    logic [7:0] m_len = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pay.delete();
        m_hold = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit e, output logic [1:0] c);
        logic [7:0] x;
        e = 1'b0;
        c = 2'd0;
        if (m_hold) begin
            e = 1'b1;
            c = 2'd0;
        end else if (mq.size() == 0) begin
            if (b == 8'hA5) mq.push_back(b);
        end else begin
            mq.push_back(b);
            if (mq.size() == 3 && int'(mq[2]) > MAXP) begin
                e = 1'b1;
                c = 2'd1;
                mq.delete();
            end else if (mq.size() >= 4 && mq.size() == 4 + int'(mq[2])) begin
                x = 8'h00;
                for (int i = 1; i < mq.size() - 1; i++) x = x ^ mq[i];
                if (x == b) begin
                    m_hold = 1'b1;
                    m_opc  = mq[1];
                    m_len  = mq[2];
                    m_pay.delete();
                    for (int i = 3; i < mq.size() - 1; i++) m_pay.push_back(mq[i]);
                end else begin
                    e = 1'b1;
                    c = 2'd2;
                end
                mq.delete();
            end
        end
    endtask

    task automatic drive(input bit dv, input logic [7:0] b, input bit ack);
        bit         e;
        logic [1:0] c;
        bit         was_hold;
        bus.i_Rx_DV     = dv;
        bus.i_Rx_Byte   = b;
        bus.i_Frame_Ack = ack;
        @(posedge clk);
        #1;
        bus.i_Rx_DV     = 1'b0;
        bus.i_Frame_Ack = 1'b0;
        was_hold = m_hold;
        e = 1'b0;
        c = 2'd0;
        if (dv) model_byte(b, e, c);
        if (ack && was_hold) m_hold = 1'b0;
        check("err", bus.o_Err, e);
        if (e) check("err_code", bus.o_Err_Code, c);
        check("valid", bus.o_Frame_Valid, m_hold);
        if (m_hold) begin
            check("opcode", bus.o_Opcode, m_opc);
            check("length", bus.o_Length, m_len);
        end
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        drive(1'b1, b, 1'b0);
        repeat ($urandom_range(0, max_gap)) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < int'(m_len); i++) begin
            bus.i_Rd_Addr = 4'(i);
            drive(1'b0, 8'h00, 1'b0);
            check("rd_data", bus.o_Rd_Data, m_pay[i]);
        end
    endtask

    task automatic send_list(input logic [7:0] bl[$], input int max_gap);
        foreach (bl[i]) send(bl[i], max_gap);
    endtask

    initial begin
        logic [7:0] fb[$];
        logic [7:0] opc, len, cks, p, g;
        int         k;
        bit         seen;

        bus.i_Rx_DV     = 1'b0;
        bus.i_Rx_Byte   = 8'h00;
        bus.i_Frame_Ack = 1'b0;
        bus.i_Rd_Addr   = '0;

        #2;
        check("rst_valid", bus.o_Frame_Valid, 1'b0);
        check("rst_err", bus.o_Err, 1'b0);
        check("rst_code", bus.o_Err_Code, 2'd0);
        check("rst_opcode", bus.o_Opcode, 8'h00);
        check("rst_length", bus.o_Length, 8'h00);
        check("rst_rd_data", bus.o_Rd_Data, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        fb = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22};
        send_list(fb, 0);
        drive(1'b1, 8'h30, 1'b0);
        check("good_valid_1clk", bus.o_Frame_Valid, 1'b1);
        read_all();
        drive(1'b0, 8'h00, 1'b1);
        check("good_ack_fall", bus.o_Frame_Valid, 1'b0);

        fb = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22};
        send_list(fb, 1);
        drive(1'b1, 8'h31, 1'b0);
        check("cks_err_pulse", bus.o_Err, 1'b1);
        check("cks_err_code", bus.o_Err_Code, 2'd2);
        drive(1'b0, 8'h00, 1'b0);
        fb = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        send_list(fb, 0);
        check("after_cks_valid", bus.o_Frame_Valid, 1'b1);
        read_all();
        drive(1'b0, 8'h00, 1'b1);

        fb = '{8'hA5, 8'h07, 8'h00, 8'h07};
        send_list(fb, 0);
        check("zero_len_valid", bus.o_Frame_Valid, 1'b1);
        check("zero_len_length", bus.o_Length, 8'h00);
        drive(1'b0, 8'h00, 1'b1);
        fb = '{8'hA5, 8'h07};
        send_list(fb, 0);
        drive(1'b1, 8'h11, 1'b0);
        check("len_err_code", bus.o_Err_Code, 2'd1);
        check("len_err_pulse", bus.o_Err, 1'b1);

        fb = '{8'hA5, 8'h01, 8'h00, 8'h01};
        send_list(fb, 0);
        drive(1'b1, 8'hA5, 1'b1);
        check("ovr_code", bus.o_Err_Code, 2'd0);
        check("ovr_valid_fall", bus.o_Frame_Valid, 1'b0);
        send_list(fb, 0);
        check("after_ovr_valid", bus.o_Frame_Valid, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        fb = '{8'hA5, 8'h01, 8'h02, 8'h11};
        send_list(fb, 0);
`ifdef UART_FRAME_TIMEOUT_EN
        k = 0;
        seen = 1'b0;
        while (!seen && k < TO + 10) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.o_Err) seen = 1'b1;
        end
        check("timeout_cycle", k, TO);
        check("timeout_code", bus.o_Err_Code, 2'd3);
        model_reset();
        drive(1'b0, 8'h00, 1'b0);
`else
        seen = 1'b0;
        for (int i = 0; i < TO + 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_Err) seen = 1'b1;
        end
        check("no_timeout_err", seen, 1'b0);
        send(8'h22, 0);
        send(8'h30, 0);
        check("late_frame_valid", bus.o_Frame_Valid, 1'b1);
        read_all();
        drive(1'b0, 8'h00, 1'b1);
`endif

        fb = '{8'hA5, 8'h01, 8'h02, 8'h11};
        send_list(fb, 0);
        check("mid_opcode", bus.o_Opcode, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("arst_opcode", bus.o_Opcode, 8'h00);
        check("arst_length", bus.o_Length, 8'h00);
        check("arst_valid", bus.o_Frame_Valid, 1'b0);
        check("arst_rd_data", bus.o_Rd_Data, 8'h00);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        fb = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h33, 8'h44};
        send_list(fb, 1);
        drive(1'b1, 8'h01 ^ 8'h02 ^ 8'h33 ^ 8'h44, 1'b0);
        check("after_rst_valid", bus.o_Frame_Valid, 1'b1);
        read_all();
        drive(1'b0, 8'h00, 1'b1);

        for (int f = 0; f < 60; f++) begin
            fb.delete();
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                fb.push_back(g);
            end
            opc = 8'($urandom);
            len = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(MAXP + 1, 255))
                                              : 8'($urandom_range(0, MAXP));
            fb.push_back(8'hA5);
            fb.push_back(opc);
            fb.push_back(len);
            if (int'(len) <= MAXP) begin
                cks = opc ^ len;
                for (int i = 0; i < int'(len); i++) begin
                    p = 8'($urandom);
                    fb.push_back(p);
                    cks = cks ^ p;
                end
                if ($urandom_range(0, 3) == 0) cks = cks ^ 8'($urandom_range(1, 255));
                fb.push_back(cks);
            end
            send_list(fb, 2);
            if (m_hold) begin
                read_all();
                if ($urandom_range(0, 2) == 0) drive(1'b1, 8'($urandom), 1'b1);
                else                           drive(1'b0, 8'h00, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
